// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter
// Purpose  : Two-requester write arbiter for the single register file write
//            port. Define REGFILE_ARB_ROUND_ROBIN_EN for round-robin on contention.
// Revision : 1.0
// ============================================================================
module regfile_write_arbiter #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int REG_SIZE      = 32
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          a_valid,
  output logic                          a_ready,
  input  logic [ADDRESS_WIDTH-1:0]      a_addr,
  input  logic [REG_SIZE-1:0]           a_data,
  input  logic                          b_valid,
  output logic                          b_ready,
  input  logic [ADDRESS_WIDTH-1:0]      b_addr,
  input  logic [REG_SIZE-1:0]           b_data,
  output logic                          write_en,
  output logic [ADDRESS_WIDTH-1:0]      write_reg_addr,
  output logic [REG_SIZE-1:0]           write_reg_data_in,
  output logic [(1<<ADDRESS_WIDTH)-1:0] pending_mask,
  output logic                          idle
);

  localparam int NUM_REGS = 1 << ADDRESS_WIDTH;

  logic                     hold_a_full_q, hold_a_full_d;
  logic [ADDRESS_WIDTH-1:0] hold_a_addr_q, hold_a_addr_d;
  logic [REG_SIZE-1:0]      hold_a_data_q, hold_a_data_d;
  logic                     hold_b_full_q, hold_b_full_d;
  logic [ADDRESS_WIDTH-1:0] hold_b_addr_q, hold_b_addr_d;
  logic [REG_SIZE-1:0]      hold_b_data_q, hold_b_data_d;
  logic                     write_en_q, write_en_d;
  logic [ADDRESS_WIDTH-1:0] write_addr_q, write_addr_d;
  logic [REG_SIZE-1:0]      write_data_q, write_data_d;
  logic [NUM_REGS-1:0]      pending_q, pending_d;

  logic prefer_a;
  logic grant_a, grant_b;
  logic accept_a, accept_b;

`ifdef REGFILE_ARB_ROUND_ROBIN_EN
  // rr_q = 0: A is preferred on the next contended cycle.
  logic rr_q, rr_d;

  always_comb begin
    rr_d = rr_q;
    if (hold_a_full_q && hold_b_full_q) begin
      rr_d = grant_a;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end

  assign prefer_a = !rr_q;
`else
  assign prefer_a = 1'b1;
`endif

  assign grant_a  = hold_a_full_q && (!hold_b_full_q || prefer_a);
  assign grant_b  = hold_b_full_q && !grant_a;

  // Ready is a function of state only, so a hold being drained may refill.
  assign a_ready  = !hold_a_full_q || grant_a;
  assign b_ready  = !hold_b_full_q || grant_b;
  assign accept_a = a_valid && a_ready;
  assign accept_b = b_valid && b_ready;

  always_comb begin
    hold_a_full_d = hold_a_full_q;
    hold_a_addr_d = hold_a_addr_q;
    hold_a_data_d = hold_a_data_q;
    hold_b_full_d = hold_b_full_q;
    hold_b_addr_d = hold_b_addr_q;
    hold_b_data_d = hold_b_data_q;

    if (accept_a) begin
      hold_a_full_d = (a_addr != '0);
      hold_a_addr_d = a_addr;
      hold_a_data_d = a_data;
    end else if (grant_a) begin
      hold_a_full_d = 1'b0;
    end

    if (accept_b) begin
      hold_b_full_d = (b_addr != '0);
      hold_b_addr_d = b_addr;
      hold_b_data_d = b_data;
    end else if (grant_b) begin
      hold_b_full_d = 1'b0;
    end
  end

  always_comb begin
    write_en_d   = grant_a || grant_b;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;
    if (grant_a) begin
      write_addr_d = hold_a_addr_q;
      write_data_d = hold_a_data_q;
    end else if (grant_b) begin
      write_addr_d = hold_b_addr_q;
      write_data_d = hold_b_data_q;
    end
  end

  // Clear on commit first so that a same-cycle accept to that register wins.
  always_comb begin
    pending_d = pending_q;
    if (write_en_q) begin
      pending_d[write_addr_q] = 1'b0;
    end
    if (accept_a && (a_addr != '0)) begin
      pending_d[a_addr] = 1'b1;
    end
    if (accept_b && (b_addr != '0)) begin
      pending_d[b_addr] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_a_full_q <= 1'b0;
      hold_a_addr_q <= '0;
      hold_a_data_q <= '0;
      hold_b_full_q <= 1'b0;
      hold_b_addr_q <= '0;
      hold_b_data_q <= '0;
      write_en_q    <= 1'b0;
      write_addr_q  <= '0;
      write_data_q  <= '0;
      pending_q     <= '0;
    end else begin
      hold_a_full_q <= hold_a_full_d;
      hold_a_addr_q <= hold_a_addr_d;
      hold_a_data_q <= hold_a_data_d;
      hold_b_full_q <= hold_b_full_d;
      hold_b_addr_q <= hold_b_addr_d;
      hold_b_data_q <= hold_b_data_d;
      write_en_q    <= write_en_d;
      write_addr_q  <= write_addr_d;
      write_data_q  <= write_data_d;
      pending_q     <= pending_d;
    end
  end

  assign write_en          = write_en_q;
  assign write_reg_addr    = write_addr_q;
  assign write_reg_data_in = write_data_q;
  assign pending_mask      = pending_q;
  assign idle              = !hold_a_full_q && !hold_b_full_q && !write_en_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_write_arbiter
// Purpose  : Scoreboard bench for regfile_write_arbiter (directed vectors).
// Revision : 1.0
// ============================================================================
module tb_regfile_write_arbiter;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic        a_ready, b_ready;
  logic [4:0]  a_addr = '0, b_addr = '0;
  logic [31:0] a_data = '0, b_data = '0;
  logic        write_en;
  logic [4:0]  write_reg_addr;
  logic [31:0] write_reg_data_in;
  logic [31:0] pending_mask;
  logic        idle;

  int n_cmp = 0;
  int n_err = 0;

  wr_t exp_q[$];
  wr_t qa[$];
  wr_t qb[$];

  regfile_write_arbiter #(.ADDRESS_WIDTH(5), .REG_SIZE(32)) dut (
    .clock(clock), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .write_en(write_en), .write_reg_addr(write_reg_addr),
    .write_reg_data_in(write_reg_data_in),
    .pending_mask(pending_mask), .idle(idle)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every issued write is popped against the scoreboard.
  initial begin
    wr_t e;
    forever begin
      @(negedge clock);
      if (reset && write_en) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_write: got r%0d=0x%0h expected none",
                   write_reg_addr, write_reg_data_in);
        end else begin
          e = exp_q.pop_front();
          if (write_reg_addr !== e.addr || write_reg_data_in !== e.data) begin
            n_err++;
            $display("FAIL write: got r%0d=0x%0h expected r%0d=0x%0h",
                     write_reg_addr, write_reg_data_in, e.addr, e.data);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clock);
    a_valid = 1'b0;
    b_valid = 1'b0;
    reset   = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || !idle) && n < 40) begin
      @(negedge clock);
      n++;
    end
    check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    check({name, "_pending_clear"}, 64'(pending_mask), 64'd0);
  endtask

  // Drives qa/qb with valid held until each item is accepted.
  task automatic stream(input string name, input int budget);
    bit acc_a = 0, acc_b = 0;
    int n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < budget) begin
      @(negedge clock);
      if (acc_a) void'(qa.pop_front());
      if (acc_b) void'(qb.pop_front());
      a_valid = (qa.size() != 0);
      b_valid = (qb.size() != 0);
      if (a_valid) begin a_addr = qa[0].addr; a_data = qa[0].data; end
      if (b_valid) begin b_addr = qb[0].addr; b_data = qb[0].data; end
      #1;
      acc_a = a_valid && a_ready;
      acc_b = b_valid && b_ready;
      n++;
    end
    check({name, "_stream_done"}, 64'(qa.size() + qb.size()), 64'd0);
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  initial begin
    // Reset values
    #1;
    check("rst_write_en", 64'(write_en), 64'd0);
    check("rst_addr", 64'(write_reg_addr), 64'd0);
    check("rst_data", 64'(write_reg_data_in), 64'd0);
    check("rst_pending", 64'(pending_mask), 64'd0);
    check("rst_ready", {62'd0, a_ready, b_ready}, 64'd3);
    check("rst_idle", 64'(idle), 64'd1);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // Single write r3
    @(negedge clock);
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'hDEADBEEF;
    exp_q.push_back('{5'd3, 32'hDEADBEEF});
    #1 check("single_a_ready", 64'(a_ready), 64'd1);
    @(negedge clock);
    a_valid = 1'b0;
    check("single_pending_set", 64'(pending_mask), 64'h8);
    check("single_not_idle", 64'(idle), 64'd0);
    @(negedge clock);
    check("single_write_en", 64'(write_en), 64'd1);
    check("single_pending_hold", 64'(pending_mask), 64'h8);
    @(negedge clock);
    check("single_pending_clr", 64'(pending_mask), 64'h0);
    drain("single");

    // Collision: A r4, B r5 on the same edge
    do_reset();
    @(negedge clock);
    a_valid = 1'b1; a_addr = 5'd4; a_data = 32'h11;
    b_valid = 1'b1; b_addr = 5'd5; b_data = 32'h22;
    exp_q.push_back('{5'd4, 32'h11});
    exp_q.push_back('{5'd5, 32'h22});
    #1 check("coll_ready0", {62'd0, a_ready, b_ready}, 64'd3);
    @(negedge clock);
    a_valid = 1'b0; b_valid = 1'b0;
    check("coll_b_stall", {62'd0, a_ready, b_ready}, 64'd2);
    check("coll_pending_both", 64'(pending_mask), 64'h30);
    @(negedge clock);
    check("coll_b_ready_again", 64'(b_ready), 64'd1);
    check("coll_pending_hold", 64'(pending_mask), 64'h30);
    @(negedge clock);
    check("coll_pending_r4_clr", 64'(pending_mask), 64'h20);
    @(negedge clock);
    check("coll_pending_r5_clr", 64'(pending_mask), 64'h0);
    drain("coll");

    // r0 discard from B
    @(negedge clock);
    b_valid = 1'b1; b_addr = 5'd0; b_data = 32'hFFFFFFFF;
    #1 check("r0_b_ready", 64'(b_ready), 64'd1);
    @(negedge clock);
    b_valid = 1'b0;
    check("r0_pending", 64'(pending_mask), 64'h0);
    check("r0_idle", 64'(idle), 64'd1);
    repeat (3) @(negedge clock);
    check("r0_no_write", 64'(write_en), 64'd0);

    // Sustained contention: six items per requester
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      qa.push_back('{5'(i), 32'hA0 + 32'(i)});
      qb.push_back('{5'(i + 16), 32'hB0 + 32'(i)});
    end
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
    for (int i = 1; i <= 6; i++) begin
      exp_q.push_back('{5'(i), 32'hA0 + 32'(i)});
      exp_q.push_back('{5'(i + 16), 32'hB0 + 32'(i)});
    end
`else
    for (int i = 1; i <= 6; i++) exp_q.push_back('{5'(i), 32'hA0 + 32'(i)});
    for (int i = 1; i <= 6; i++) exp_q.push_back('{5'(i + 16), 32'hB0 + 32'(i)});
`endif
    stream("contend", 40);
    drain("contend");

    // Refill: A streams r7, r8, r9 back to back
    @(negedge clock);
    a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h7;
    exp_q.push_back('{5'd7, 32'h7});
    #1 check("refill_ready_r7", 64'(a_ready), 64'd1);
    @(negedge clock);
    a_addr = 5'd8; a_data = 32'h8;
    exp_q.push_back('{5'd8, 32'h8});
    #1 check("refill_ready_r8", 64'(a_ready), 64'd1);
    @(negedge clock);
    a_addr = 5'd9; a_data = 32'h9;
    exp_q.push_back('{5'd9, 32'h9});
    #1 check("refill_ready_r9", 64'(a_ready), 64'd1);
    check("refill_we1", 64'(write_en), 64'd1);
    @(negedge clock);
    a_valid = 1'b0;
    check("refill_we2", 64'(write_en), 64'd1);
    @(negedge clock);
    check("refill_we3", 64'(write_en), 64'd1);
    @(negedge clock);
    check("refill_we_off", 64'(write_en), 64'd0);
    drain("refill");

    // Reset asserted mid-stream drops held writes
    @(negedge clock);
    a_valid = 1'b1; a_addr = 5'd10; a_data = 32'h1010;
    b_valid = 1'b1; b_addr = 5'd11; b_data = 32'h1111;
    @(negedge clock);
    a_valid = 1'b0; b_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("midrst_write_en", 64'(write_en), 64'd0);
    check("midrst_pending", 64'(pending_mask), 64'd0);
    check("midrst_ready", {62'd0, a_ready, b_ready}, 64'd3);
    check("midrst_idle", 64'(idle), 64'd1);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (6) @(negedge clock);
    check("midrst_idle_after", 64'(idle), 64'd1);
    check("midrst_pending_after", 64'(pending_mask), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
